// File: rtl/outbuf_vc_fifo_if.sv
// Crossbar-to-link bundle for the virtual-channel output buffer.
// Master is the side that feeds flits and phase/ready controls; slave is the buffer itself.
interface outbuf_vc_fifo_if #(
  parameter int DW     = 64,
  parameter int DEPTH  = 4,
  parameter int NUM_VC = 2
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    enq;
  logic [VC_W-1:0]         enq_vc;
  logic [DW-1:0]           d_in;
  logic [NUM_VC-1:0]       phase_int;
  logic [NUM_VC-1:0]       phase_ext;
  logic                    so;
  logic [VC_W-1:0]         so_vc;
  logic                    ro;
  logic [DW-1:0]           dout;
  logic [NUM_VC-1:0]       full;
  logic [NUM_VC-1:0]       empty;
  logic [NUM_VC*CNT_W-1:0] count;
  logic                    ovf_err;

  modport master (
    output enq, enq_vc, d_in, phase_int, phase_ext, ro,
    input  so, so_vc, dout, full, empty, count, ovf_err
  );

  modport slave (
    input  enq, enq_vc, d_in, phase_int, phase_ext, ro,
    output so, so_vc, dout, full, empty, count, ovf_err
  );
endinterface

// File: rtl/outbuf_vc_fifo.sv
// Router output buffer: NUM_VC independent FIFOs, enqueue gated by internal phase,
// send gated by external phase and neighbour ready, lowest eligible VC wins the link.
module outbuf_vc_fifo #(
  parameter int DW     = 64,
  parameter int DEPTH  = 4,
  parameter int NUM_VC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  outbuf_vc_fifo_if.slave   bus
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]     mem  [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wptr [NUM_VC];
  logic [PTR_W-1:0]  rptr [NUM_VC];
  logic [CNT_W-1:0]  cnt  [NUM_VC];
  logic              ovf_q;

  logic [NUM_VC-1:0] hit;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] full_v;
  logic [NUM_VC-1:0] empty_v;
  logic              ovf_now;
  logic              valid;
  logic [VC_W-1:0]   sel;
  logic [DW-1:0]     head;

  // Per-VC decode and send arbitration; full is taken from pre-edge state so a
  // full VC never reuses the slot being freed in the same cycle.
  always_comb begin
    hit     = '0;
    push    = '0;
    pop     = '0;
    full_v  = '0;
    empty_v = '0;
    ovf_now = 1'b0;
    valid   = 1'b0;
    sel     = '0;
    head    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full_v[v]  = (cnt[v] == CNT_W'(DEPTH));
      empty_v[v] = (cnt[v] == '0);
      hit[v]     = bus.enq && (bus.enq_vc == VC_W'(v));
      push[v]    = hit[v] && bus.phase_int[v] && !full_v[v];
      if (hit[v] && bus.phase_int[v] && full_v[v]) ovf_now = 1'b1;
      if (!valid && bus.phase_ext[v] && !empty_v[v]) begin
        valid = 1'b1;
        sel   = VC_W'(v);
        head  = mem[v][rptr[v]];
      end
    end
    // An enqueue whose VC number matches no channel is an error regardless of phase.
    if (bus.enq && (hit == '0)) ovf_now = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v] = valid && bus.ro && (sel == VC_W'(v));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wptr[v] <= '0;
        rptr[v] <= '0;
        cnt[v]  <= '0;
        for (int e = 0; e < DEPTH; e++) mem[v][e] <= '0;
      end
    end else begin
      ovf_q <= ovf_q | ovf_now;
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) begin
          mem[v][wptr[v]] <= bus.d_in;
          wptr[v] <= (wptr[v] == PTR_W'(DEPTH - 1)) ? '0 : wptr[v] + PTR_W'(1);
        end
        if (pop[v]) begin
          rptr[v] <= (rptr[v] == PTR_W'(DEPTH - 1)) ? '0 : rptr[v] + PTR_W'(1);
        end
        case ({push[v], pop[v]})
          2'b10:   cnt[v] <= cnt[v] + CNT_W'(1);
          2'b01:   cnt[v] <= cnt[v] - CNT_W'(1);
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  assign bus.so      = valid && bus.ro;
  assign bus.so_vc   = sel;
  assign bus.dout    = head;
  assign bus.full    = full_v;
  assign bus.empty   = empty_v;
  assign bus.ovf_err = ovf_q;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_count
    assign bus.count[g*CNT_W +: CNT_W] = cnt[g];
  end
endmodule

// File: tb/tb_outbuf_vc_fifo.sv
// Directed bench for outbuf_vc_fifo: a DEPTH=4 instance for the main scenarios and a
// DEPTH=3 instance for pointer wrap, non-power-of-two full and VC priority.
module tb_outbuf_vc_fifo;
  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  outbuf_vc_fifo_if #(.DW(64), .DEPTH(4), .NUM_VC(2)) a ();
  outbuf_vc_fifo_if #(.DW(64), .DEPTH(3), .NUM_VC(2)) b ();

  outbuf_vc_fifo #(.DW(64), .DEPTH(4), .NUM_VC(2)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(a));
  outbuf_vc_fifo #(.DW(64), .DEPTH(3), .NUM_VC(2)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    a.enq = 0; a.enq_vc = 0; a.d_in = 0; a.phase_int = 0; a.phase_ext = 0; a.ro = 0;
    b.enq = 0; b.enq_vc = 0; b.d_in = 0; b.phase_int = 0; b.phase_ext = 0; b.ro = 0;
    #12;
    chk("rst_so", a.so, 0);
    chk("rst_empty", a.empty, 2'b11);
    chk("rst_full", a.full, 0);
    chk("rst_count", a.count, 0);
    chk("rst_dout", a.dout, 0);
    chk("rst_ovf", a.ovf_err, 0);
    reset_n = 1'b1;
    step();

    // 1: reset mid-traffic
    a.phase_int = 2'b01; a.enq = 1; a.enq_vc = 0; a.d_in = 64'h11;
    step();
    a.enq = 0; a.phase_int = 0; a.phase_ext = 2'b11; a.ro = 0;
    #1;
    chk("t1_pre_dout", a.dout, 64'h11);
    chk("t1_pre_count", a.count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_dout", a.dout, 0);
    chk("t1_async_empty", a.empty, 2'b11);
    chk("t1_async_count", a.count, 0);
    #1 reset_n = 1'b1;
    a.ro = 1;
    step();
    step();
    chk("t1_post_so", a.so, 0);
    chk("t1_post_empty", a.empty, 2'b11);
    a.phase_ext = 0; a.ro = 0;

    // 2: fill and drain VC0
    a.phase_int = 2'b01; a.enq = 1; a.enq_vc = 0;
    for (int i = 0; i < 4; i++) begin
      a.d_in = 64'hA0 + 64'(i);
      step();
    end
    chk("t2_count_full", a.count[2:0], 4);
    chk("t2_full", a.full, 2'b01);
    chk("t2_ovf_before", a.ovf_err, 0);
    a.d_in = 64'hA4;
    step();
    chk("t2_ovf", a.ovf_err, 1);
    chk("t2_count_after_ovf", a.count[2:0], 4);
    a.enq = 0; a.phase_int = 0;
    a.phase_ext = 2'b01; a.ro = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_dout", a.dout, 64'hA0 + 64'(i));
      chk("t2_drain_so", a.so, 1);
      step();
    end
    chk("t2_empty", a.empty, 2'b11);
    chk("t2_so_done", a.so, 0);
    chk("t2_dout_done", a.dout, 0);
    a.phase_ext = 0; a.ro = 0;

    // 3: backpressure on VC1
    do_reset();
    a.phase_int = 2'b10; a.enq = 1; a.enq_vc = 1; a.d_in = 64'hB0;
    step();
    a.enq = 0; a.phase_int = 0; a.phase_ext = 2'b10; a.ro = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_dout", a.dout, 64'hB0);
      chk("t3_hold_so", a.so, 0);
      chk("t3_hold_count", a.count[5:3], 1);
      step();
    end
    a.ro = 1;
    #1;
    chk("t3_send_so", a.so, 1);
    chk("t3_send_vc", a.so_vc, 1);
    step();
    chk("t3_after_count", a.count[5:3], 0);
    chk("t3_after_dout", a.dout, 0);
    chk("t3_after_so", a.so, 0);
    a.phase_ext = 0; a.ro = 0;

    // 4: phase gating
    do_reset();
    a.phase_int = 2'b00; a.enq = 1; a.enq_vc = 0; a.d_in = 64'hC0;
    step();
    chk("t4_gated_count", a.count[2:0], 0);
    chk("t4_gated_ovf", a.ovf_err, 0);
    a.phase_int = 2'b01; a.d_in = 64'hC1;
    step();
    a.enq = 0; a.phase_int = 0; a.phase_ext = 2'b00; a.ro = 1;
    #1;
    chk("t4_noext_dout", a.dout, 0);
    chk("t4_noext_so", a.so, 0);
    step();
    chk("t4_noext_count", a.count[2:0], 1);
    a.phase_ext = 2'b01;
    #1;
    chk("t4_ext_dout", a.dout, 64'hC1);
    step();
    a.phase_ext = 0; a.ro = 0;

    // 5: simultaneous enqueue and send on VC0
    do_reset();
    a.phase_int = 2'b01; a.enq = 1; a.enq_vc = 0;
    a.d_in = 64'hD0; step();
    a.d_in = 64'hD1; step();
    a.d_in = 64'hD2; a.phase_ext = 2'b01; a.ro = 1;
    #1;
    chk("t5_both_dout", a.dout, 64'hD0);
    step();
    chk("t5_both_count", a.count[2:0], 2);
    a.enq = 0; a.phase_int = 0;
    for (int i = 1; i < 3; i++) begin
      #1;
      chk("t5_order", a.dout, 64'hD0 + 64'(i));
      step();
    end
    chk("t5_empty", a.empty[0], 1);
    a.phase_ext = 0;
    a.phase_int = 2'b01; a.enq = 1;
    for (int i = 0; i < 4; i++) begin
      a.d_in = 64'hE0 + 64'(i);
      step();
    end
    chk("t5_full", a.full[0], 1);
    a.d_in = 64'hE4; a.phase_ext = 2'b01; a.ro = 1;
    #1;
    chk("t5_full_so", a.so, 1);
    chk("t5_full_dout", a.dout, 64'hE0);
    step();
    chk("t5_full_count", a.count[2:0], 3);
    chk("t5_full_ovf", a.ovf_err, 1);
    a.enq = 0; a.phase_int = 0;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("t5_full_order", a.dout, 64'hE0 + 64'(i));
      step();
    end
    chk("t5_drop_empty", a.empty[0], 1);
    a.phase_ext = 0; a.ro = 0;

    // 6: DEPTH=3 wrap on VC1, then priority
    do_reset();
    b.phase_int = 2'b10; b.enq = 1; b.enq_vc = 1; b.d_in = 64'hF0;
    step();
    b.phase_ext = 2'b10; b.ro = 1;
    for (int i = 0; i < 10; i++) begin
      b.d_in = 64'hF1 + 64'(i);
      #1;
      chk("t6_wrap_dout", b.dout, 64'hF0 + 64'(i));
      step();
      chk("t6_wrap_count", b.count[3:2], 1);
    end
    b.enq = 0; b.phase_int = 0;
    #1;
    chk("t6_wrap_last", b.dout, 64'hFA);
    step();
    chk("t6_wrap_empty", b.empty, 2'b11);
    b.phase_ext = 0; b.ro = 0;
    b.phase_int = 2'b10; b.enq = 1; b.enq_vc = 1;
    for (int i = 1; i < 4; i++) begin
      b.d_in = 64'h30 + 64'(i);
      step();
    end
    chk("t6_full", b.full, 2'b10);
    chk("t6_full_count", b.count[3:2], 3);
    b.phase_int = 2'b01; b.enq_vc = 0; b.d_in = 64'h40;
    step();
    b.enq = 0; b.phase_int = 0; b.phase_ext = 2'b11; b.ro = 1;
    #1;
    chk("t6_prio_vc", b.so_vc, 0);
    chk("t6_prio_dout", b.dout, 64'h40);
    step();
    for (int i = 1; i < 4; i++) begin
      chk("t6_vc1_vc", b.so_vc, 1);
      chk("t6_vc1_dout", b.dout, 64'h30 + 64'(i));
      step();
    end
    chk("t6_end_so", b.so, 0);
    chk("t6_end_ovf", b.ovf_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
